glitc_settings_update_scheduler: RTL and testbench
==================================================

// Module: glitc_settings_update_scheduler
// PURPOSE
//  Parametrised settings shadow bank + hardware update scheduler for GLITC external devices (Vped DACs, attenuators).
//  Holds user-written values, tracks per-channel update-pending, picks pending channels round-robin and issues one
//  update at a time over a valid/ready/done command interface to the I2C sequencer. Adds retry, error FIFO and pause.
// PARAMETERS
//  NUM_DAC    8  number of DAC channels (1..16)
//  NUM_ATT    6  number of attenuator channels (1..8)
//  DAC_W     12  DAC value width (<=16)
//  ATT_W      6  attenuator value width (<=8)
//  ERR_DEPTH  8  error FIFO depth, power of 2
//  MAX_RETRY  3  attempts per update before logging error (>=1)
// PORTS
//  user_clk_i    in   1   sole clock
//  user_rst_n_i  in   1   asynchronous reset, active low
//  user_sel_i    in   1   register select
//  user_wr_i     in   1   write strobe (with sel)
//  user_rd_i     in   1   read strobe (with sel; pops error FIFO at 0x1F)
//  user_addr_i   in   5   register address
//  user_dat_i    in   32  write data
//  user_dat_o    out  32  read data, combinational mux of user_addr_i
//  upd_valid_o   out  1   update request valid
//  upd_ready_i   in   1   sequencer accepts request
//  upd_type_o    out  1   0=DAC, 1=attenuator
//  upd_chan_o    out  4   channel index
//  upd_value_o   out  16  value, zero-extended
//  upd_eeprom_o  out  1   DAC: also commit to EEPROM; ATT: 0
//  upd_done_i    in   1   one-cycle completion pulse
//  upd_err_i     in   1   qualifies upd_done_i: attempt failed
//  busy_o        out  1   any pending or in-flight update
// BEHAVIOUR
//  Map: 0x00-0x0F DAC n {eeprom[31],value[DAC_W-1:0]}; 0x10-0x17 ATT n value; 0x1E status/ctl; 0x1F error FIFO.
//  Unimplemented channels read 0, writes ignored. Status: [7:0] fifo count, [8] fifo nonempty, [9] overflow sticky,
//  [30] pause (r/w), [31] busy. Write 0x1E bit9=1 clears overflow. Read 0x1F: {valid[31],type[8],retries[7:4]?no:0,chan[3:0]}
//  i.e. data[4]=type, [3:0]=chan, [31]=entry valid; pop on sel&rd at 0x1F when nonempty.
//  Write to channel: value/eeprom registered next edge; pending[ch] set same edge.
//  Reset: all values 0, pending 0, pause 0, FIFO empty, overflow 0, upd_valid_o 0, all upd_* outputs 0, busy_o 0, FSM IDLE.
//  FSM: IDLE -> (pending!=0 & !pause) select next pending after last-served index (DACs then ATTs, wrap) -> ISSUE.
//   ISSUE: upd_* snapshot of value at selection, held stable while valid; pending[ch] cleared on selection edge.
//   ISSUE & upd_ready_i -> WAIT (valid drops next cycle). WAIT & done & !err -> IDLE.
//   WAIT & done & err: attempts<MAX_RETRY -> ISSUE with same snapshot; else push {type,chan}, -> IDLE.
//  Latency: write at edge N -> upd_valid_o high at N+2 if idle and unpaused.
//  Same-channel write while in flight: pending re-set; in-flight snapshot unchanged; channel reissued later.
//  Simultaneous user write and selection-clear of same channel: set wins.
//  Pause: blocks IDLE->ISSUE only; in-flight update and retries complete.
//  FIFO full on push: entry dropped, overflow set. Simultaneous push and pop: both take effect, count unchanged.
//  upd_done_i outside WAIT ignored. Reset mid-transfer: everything to reset values; no request replayed.
//  busy_o = |pending | (state!=IDLE), registered.
// STRUCTURE
//  Package glitc_settings_pkg: address constants, status bit positions, UPD_TYPE_DAC/ATT, FSM state encoding.
//  Sub-module: glitc_err_fifo (sync FIFO, ERR_DEPTH x 5 bits, count/full/empty). Round-robin picker inline.
// TESTING
//  Write 0x02=0x8ABC, ready=1, done next -> one request type0 chan2 value 0x0ABC eeprom1; busy_o drops.
//  Write ATT 0,3 and DAC 5 same burst -> issue order DAC5, ATT0, ATT3; each once.
//  err on 3 attempts for DAC1 -> 3 identical requests, FIFO entry 0x80000001, status[8]=1; read 0x1F pops, count 0.
//  Pause=1, write DAC0 -> no valid for 100 cycles; pause=0 -> request within 2 cycles.
//  Write DAC4=0x111 then 0x222 while 0x111 in WAIT -> two requests: 0x111 then 0x222.
//  9 failing channels with ERR_DEPTH=8 -> 8 entries, overflow=1; reset asserted in WAIT -> all outputs 0.

Source files
------------

// File: rtl/glitc_settings_pkg.sv
// Shared constants for the GLITC settings shadow bank and update scheduler:
// register map, status bit positions, update types and FSM encoding.
package glitc_settings_pkg;

    localparam logic [4:0] ADDR_ATT_BASE = 5'h10;
    localparam logic [4:0] ADDR_STATUS   = 5'h1E;
    localparam logic [4:0] ADDR_ERR      = 5'h1F;

    localparam int ST_NONEMPTY = 8;
    localparam int ST_OVF      = 9;
    localparam int ST_PAUSE    = 30;
    localparam int ST_BUSY     = 31;

    localparam logic UPD_TYPE_DAC = 1'b0;
    localparam logic UPD_TYPE_ATT = 1'b1;

    // Flat channel index: DACs first, then attenuators (max 16 + 8 entries).
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } upd_state_e;

endpackage

// File: rtl/glitc_err_fifo.sv
// Synchronous error-log FIFO. A push while full is accepted only when a pop
// frees the slot in the same cycle; otherwise the entry is dropped.
module glitc_err_fifo
    import glitc_settings_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 5,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/glitc_settings_update_scheduler.sv
// Settings shadow bank for GLITC DACs/attenuators with a round-robin update
// scheduler, retry on sequencer error, error log FIFO and pause control.
module glitc_settings_update_scheduler
    import glitc_settings_pkg::*;
#(
    parameter int NUM_DAC   = 8,
    parameter int NUM_ATT   = 6,
    parameter int DAC_W     = 12,
    parameter int ATT_W     = 6,
    parameter int ERR_DEPTH = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic        user_clk_i,
    input  logic        user_rst_n_i,
    input  logic        user_sel_i,
    input  logic        user_wr_i,
    input  logic        user_rd_i,
    input  logic [4:0]  user_addr_i,
    input  logic [31:0] user_dat_i,
    output logic [31:0] user_dat_o,
    output logic        upd_valid_o,
    input  logic        upd_ready_i,
    output logic        upd_type_o,
    output logic [3:0]  upd_chan_o,
    output logic [15:0] upd_value_o,
    output logic        upd_eeprom_o,
    input  logic        upd_done_i,
    input  logic        upd_err_i,
    output logic        busy_o
);

    localparam int NUM_TOT = NUM_DAC + NUM_ATT;
    localparam int ACNT_W  = $clog2(MAX_RETRY + 1);
    localparam int CNT_W   = $clog2(ERR_DEPTH + 1);
    localparam logic [ACNT_W-1:0] MAX_RETRY_C = ACNT_W'(MAX_RETRY);

    logic [DAC_W-1:0]   dac_val_q [NUM_DAC];
    logic [NUM_DAC-1:0] dac_ee_q;
    logic [ATT_W-1:0]   att_val_q [NUM_ATT];
    logic [NUM_TOT-1:0] pending_q, pending_d;
    logic [NUM_TOT-1:0] wr_hit_s;
    upd_state_e         state_q, state_d;
    logic [IDX_W-1:0]   last_q, pick_q, pick_d;
    logic               pick_vld_q, pick_vld_d;
    logic [ACNT_W-1:0]  attempts_q;
    logic               pause_q, ovf_q, busy_q, busy_d;
    logic               upd_valid_q, upd_type_q, upd_eeprom_q;
    logic [3:0]         upd_chan_q;
    logic [15:0]        upd_value_q;

    logic               wr_en_s, ctl_wr_s, pop_s;
    logic               fire_s, accept_s, retry_s, log_s;
    logic               sel_att_s, sel_ee_s;
    logic [3:0]         sel_chan_s;
    logic [15:0]        sel_val_s;
    logic [4:0]         fifo_dat_s;
    logic [CNT_W-1:0]   fifo_cnt_s;
    logic               fifo_full_s, fifo_empty_s;

    assign wr_en_s  = user_sel_i & user_wr_i;
    assign ctl_wr_s = wr_en_s & (user_addr_i == ADDR_STATUS);
    assign pop_s    = user_sel_i & user_rd_i & (user_addr_i == ADDR_ERR) & ~fifo_empty_s;

    // Decode channel writes onto the flat channel index.
    always_comb begin
        wr_hit_s = '0;
        for (int n = 0; n < NUM_DAC; n++) begin
            wr_hit_s[n] = wr_en_s & (user_addr_i == 5'(n));
        end
        for (int n = 0; n < NUM_ATT; n++) begin
            wr_hit_s[NUM_DAC+n] = wr_en_s & (user_addr_i == (ADDR_ATT_BASE + 5'(n)));
        end
    end

    // Shadow value registers.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            for (int n = 0; n < NUM_DAC; n++) begin
                dac_val_q[n] <= '0;
            end
            for (int n = 0; n < NUM_ATT; n++) begin
                att_val_q[n] <= '0;
            end
            dac_ee_q <= '0;
        end else begin
            for (int n = 0; n < NUM_DAC; n++) begin
                if (wr_hit_s[n]) begin
                    dac_val_q[n] <= user_dat_i[DAC_W-1:0];
                    dac_ee_q[n]  <= user_dat_i[31];
                end
            end
            for (int n = 0; n < NUM_ATT; n++) begin
                if (wr_hit_s[NUM_DAC+n]) begin
                    att_val_q[n] <= user_dat_i[ATT_W-1:0];
                end
            end
        end
    end

    // Round-robin pick: lowest pending index above last served, else lowest overall.
    always_comb begin
        logic             hi_found, lo_found;
        logic [IDX_W-1:0] hi_idx, lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int n = NUM_TOT - 1; n >= 0; n--) begin
            if (pending_q[n]) begin
                if (IDX_W'(n) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(n);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(n);
                end
            end else begin
                hi_found = hi_found;
            end
        end
        if (hi_found) begin
            pick_d = hi_idx;
        end else begin
            pick_d = lo_idx;
        end
        pick_vld_d = (state_q == ST_IDLE) & ~fire_s & (hi_found | lo_found);
    end

    // Snapshot of the picked channel's type, channel number, value and EEPROM flag.
    always_comb begin
        sel_att_s  = (pick_q >= IDX_W'(NUM_DAC));
        sel_val_s  = 16'h0000;
        sel_ee_s   = 1'b0;
        sel_chan_s = 4'h0;
        for (int n = 0; n < NUM_DAC; n++) begin
            if (pick_q == IDX_W'(n)) begin
                sel_val_s  = 16'(dac_val_q[n]);
                sel_ee_s   = dac_ee_q[n];
                sel_chan_s = 4'(n);
            end else begin
                sel_ee_s = sel_ee_s;
            end
        end
        for (int n = 0; n < NUM_ATT; n++) begin
            if (pick_q == IDX_W'(NUM_DAC + n)) begin
                sel_val_s  = 16'(att_val_q[n]);
                sel_chan_s = 4'(n);
            end else begin
                sel_ee_s = sel_ee_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_q && !pause_q) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (upd_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (upd_done_i && upd_err_i && (attempts_q < MAX_RETRY_C)) begin
                    state_d = ST_ISSUE;
                end else if (upd_done_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode into datapath controls.
    always_comb begin
        fire_s   = 1'b0;
        accept_s = 1'b0;
        retry_s  = 1'b0;
        log_s    = 1'b0;
        case (state_q)
            ST_IDLE:  fire_s   = pick_vld_q & ~pause_q;
            ST_ISSUE: accept_s = upd_ready_i;
            ST_WAIT: begin
                retry_s = upd_done_i & upd_err_i & (attempts_q < MAX_RETRY_C);
                log_s   = upd_done_i & upd_err_i & ~(attempts_q < MAX_RETRY_C);
            end
            default: fire_s = 1'b0;
        endcase
    end

    // Pending bits: clear on selection, then a user write sets (set wins).
    always_comb begin
        pending_d = pending_q;
        for (int n = 0; n < NUM_TOT; n++) begin
            if (fire_s && (pick_q == IDX_W'(n))) begin
                pending_d[n] = 1'b0;
            end else begin
                pending_d[n] = pending_d[n];
            end
            if (wr_hit_s[n]) begin
                pending_d[n] = 1'b1;
            end else begin
                pending_d[n] = pending_d[n];
            end
        end
        busy_d = (|pending_d) | (state_d != ST_IDLE);
    end

    // Scheduler datapath and registered request outputs.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            pending_q    <= '0;
            pick_q       <= '0;
            pick_vld_q   <= 1'b0;
            last_q       <= IDX_W'(NUM_TOT - 1);
            attempts_q   <= '0;
            upd_valid_q  <= 1'b0;
            upd_type_q   <= 1'b0;
            upd_chan_q   <= 4'h0;
            upd_value_q  <= 16'h0000;
            upd_eeprom_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pick_q     <= pick_d;
            pick_vld_q <= pick_vld_d;
            busy_q     <= busy_d;
            if (fire_s) begin
                last_q       <= pick_q;
                attempts_q   <= ACNT_W'(1);
                upd_valid_q  <= 1'b1;
                upd_type_q   <= sel_att_s ? UPD_TYPE_ATT : UPD_TYPE_DAC;
                upd_chan_q   <= sel_chan_s;
                upd_value_q  <= sel_val_s;
                upd_eeprom_q <= sel_att_s ? 1'b0 : sel_ee_s;
            end else if (accept_s) begin
                upd_valid_q <= 1'b0;
            end else if (retry_s) begin
                upd_valid_q <= 1'b1;
                attempts_q  <= attempts_q + ACNT_W'(1);
            end
        end
    end

    // Pause and sticky overflow control; a new overflow beats a clear.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            pause_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (ctl_wr_s) begin
                pause_q <= user_dat_i[ST_PAUSE];
            end
            if (log_s && fifo_full_s && !pop_s) begin
                ovf_q <= 1'b1;
            end else if (ctl_wr_s && user_dat_i[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    glitc_err_fifo #(
        .DEPTH (ERR_DEPTH),
        .W     (5),
        .CNT_W (CNT_W)
    ) u_err_fifo (
        .clk_i   (user_clk_i),
        .rst_n_i (user_rst_n_i),
        .push_i  (log_s),
        .pop_i   (pop_s),
        .data_i  ({upd_type_q, upd_chan_q}),
        .data_o  (fifo_dat_s),
        .count_o (fifo_cnt_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Combinational read-back mux.
    always_comb begin
        user_dat_o = 32'h0000_0000;
        for (int n = 0; n < NUM_DAC; n++) begin
            if (user_addr_i == 5'(n)) begin
                user_dat_o = {dac_ee_q[n], 31'(dac_val_q[n])};
            end else begin
                user_dat_o = user_dat_o;
            end
        end
        for (int n = 0; n < NUM_ATT; n++) begin
            if (user_addr_i == (ADDR_ATT_BASE + 5'(n))) begin
                user_dat_o = 32'(att_val_q[n]);
            end else begin
                user_dat_o = user_dat_o;
            end
        end
        if (user_addr_i == ADDR_STATUS) begin
            user_dat_o = {busy_q, pause_q, 20'h00000, ovf_q, ~fifo_empty_s, 8'(fifo_cnt_s)};
        end else if ((user_addr_i == ADDR_ERR) && !fifo_empty_s) begin
            user_dat_o = {1'b1, 26'h0000000, fifo_dat_s};
        end else begin
            user_dat_o = user_dat_o;
        end
    end

    assign upd_valid_o  = upd_valid_q;
    assign upd_type_o   = upd_type_q;
    assign upd_chan_o   = upd_chan_q;
    assign upd_value_o  = upd_value_q;
    assign upd_eeprom_o = upd_eeprom_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_glitc_settings_update_scheduler.sv
// Directed bench for the settings update scheduler: scoreboard of expected
// update requests, a small sequencer responder and register read-back checks.
module tb_glitc_settings_update_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [4:0]  addr = 5'h00;
    logic [31:0] wdat = 32'h0;
    logic [31:0] rdat;
    logic        valid, ready = 1'b0, typ, ee, done = 1'b0, err = 1'b0, busy;
    logic [3:0]  chan;
    logic [15:0] value;

    typedef struct packed {
        logic        typ;
        logic [3:0]  chan;
        logic [15:0] val;
        logic        ee;
    } req_t;

    req_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    glitc_settings_update_scheduler dut (
        .user_clk_i   (clk),
        .user_rst_n_i (rst_n),
        .user_sel_i   (sel),
        .user_wr_i    (wr),
        .user_rd_i    (rd),
        .user_addr_i  (addr),
        .user_dat_i   (wdat),
        .user_dat_o   (rdat),
        .upd_valid_o  (valid),
        .upd_ready_i  (ready),
        .upd_type_o   (typ),
        .upd_chan_o   (chan),
        .upd_value_o  (value),
        .upd_eeprom_o (ee),
        .upd_done_i   (done),
        .upd_err_i    (err),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic t, input logic [3:0] c, input logic [15:0] v, input logic e);
        req_t r;
        r.typ = t; r.chan = c; r.val = v; r.ee = e;
        return r;
    endfunction

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdat = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; wdat = 32'h0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdat, exp);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        sel = 1'b1; rd = 1'b1; addr = 5'h1F;
        #1;
        chk(tag, rdat, exp);
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
    endtask

    // Wait for a request, compare it with the scoreboard head, handshake it.
    task automatic accept_req(input string tag);
        req_t exp_r, got;
        int   waited;
        waited = 0;
        while (!valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 32'(valid), 32'h1);
        if (valid) begin
            got = mk(typ, chan, value, ee);
            if (exp_q.size() > 0) begin
                exp_r = exp_q.pop_front();
                chk({tag, "_req"}, 32'(got), 32'(exp_r));
            end else begin
                chk({tag, "_unexpected_req"}, 32'(got), 32'h0);
            end
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            chk({tag, "_valid_drop"}, 32'(valid), 32'h0);
        end
    endtask

    task automatic finish_req(input logic e);
        done = 1'b1; err = e;
        @(negedge clk);
        done = 1'b0; err = 1'b0;
    endtask

    task automatic quiet_chk(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        chk(tag, 32'(seen), 32'h0);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_outs", {11'h0, typ, chan, value}, 32'h0);
        chk("rst_ee_busy", {30'h0, ee, busy}, 32'h0);
        read_chk("rst_status", 5'h1E, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single DAC update with EEPROM flag and 2-cycle latency
        exp_q.push_back(mk(1'b0, 4'd2, 16'h0ABC, 1'b1));
        write_reg(5'h02, 32'h8000_0ABC);
        chk("lat_n", 32'(valid), 32'h0);
        chk("busy_pending", 32'(busy), 32'h1);
        @(negedge clk);
        chk("lat_n1", 32'(valid), 32'h0);
        @(negedge clk);
        chk("lat_n2", 32'(valid), 32'h1);
        read_chk("rd_dac2", 5'h02, 32'h8000_0ABC);
        accept_req("t1");
        finish_req(1'b0);
        chk("t1_busy_drop", 32'(busy), 32'h0);
        finish_req(1'b0);
        quiet_chk("stray_done", 5);
        chk("stray_done_busy", 32'(busy), 32'h0);

        // Burst of ATT0, ATT3, DAC5 under pause; round-robin after DAC2
        write_reg(5'h1E, 32'h4000_0000);
        write_reg(5'h10, 32'h0000_0015);
        write_reg(5'h13, 32'h0000_00EA);
        write_reg(5'h05, 32'h0000_05A5);
        exp_q.push_back(mk(1'b0, 4'd5, 16'h05A5, 1'b0));
        exp_q.push_back(mk(1'b1, 4'd0, 16'h0015, 1'b0));
        exp_q.push_back(mk(1'b1, 4'd3, 16'h002A, 1'b0));
        read_chk("rd_att3", 5'h13, 32'h0000_002A);
        write_reg(5'h1E, 32'h0);
        for (int i = 0; i < 3; i++) begin
            accept_req("burst");
            finish_req(1'b0);
        end
        quiet_chk("burst_once", 10);

        // Three failed attempts on DAC1 -> logged error
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 4'd1, 16'h0123, 1'b0));
        write_reg(5'h01, 32'h0000_0123);
        for (int i = 0; i < 3; i++) begin
            accept_req("retry");
            finish_req(1'b1);
        end
        read_chk("err_status", 5'h1E, 32'h0000_0101);
        pop_chk("err_pop", 32'h8000_0001);
        read_chk("err_status_empty", 5'h1E, 32'h0);

        // Pause holds off issue; unpause issues within 2 cycles
        write_reg(5'h1E, 32'h4000_0000);
        exp_q.push_back(mk(1'b0, 4'd0, 16'h0777, 1'b0));
        write_reg(5'h00, 32'h0000_0777);
        quiet_chk("paused", 100);
        write_reg(5'h1E, 32'h0);
        lat = 0;
        while (!valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("unpause_lat_le2", 32'(lat <= 2), 32'h1);
        accept_req("unpause");
        finish_req(1'b0);

        // Rewrite of in-flight channel is reissued with the new value
        exp_q.push_back(mk(1'b0, 4'd4, 16'h0111, 1'b0));
        exp_q.push_back(mk(1'b0, 4'd4, 16'h0222, 1'b0));
        write_reg(5'h04, 32'h0000_0111);
        accept_req("inflight_a");
        write_reg(5'h04, 32'h0000_0222);
        finish_req(1'b0);
        accept_req("inflight_b");
        finish_req(1'b0);

        // Nine failing channels overflow the 8-deep error FIFO
        write_reg(5'h1E, 32'h4000_0000);
        for (int c = 0; c < 8; c++) write_reg(5'(c), 32'h100 + 32'(c));
        write_reg(5'h10, 32'h0000_0011);
        for (int k = 0; k < 9; k++) begin
            req_t r;
            if (k < 3)       r = mk(1'b0, 4'(k + 5), 16'h100 + 16'(k + 5), 1'b0);
            else if (k == 3) r = mk(1'b1, 4'd0, 16'h0011, 1'b0);
            else             r = mk(1'b0, 4'(k - 4), 16'h100 + 16'(k - 4), 1'b0);
            for (int a = 0; a < 3; a++) exp_q.push_back(r);
        end
        write_reg(5'h1E, 32'h0);
        for (int i = 0; i < 27; i++) begin
            accept_req("ovf");
            finish_req(1'b1);
        end
        read_chk("ovf_status", 5'h1E, 32'h0000_0308);
        pop_chk("ovf_first", 32'h8000_0005);
        write_reg(5'h1E, 32'h0000_0200);
        read_chk("ovf_clear", 5'h1E, 32'h0000_0107);

        // Reset while waiting for completion
        exp_q.push_back(mk(1'b0, 4'd3, 16'h00F0, 1'b0));
        write_reg(5'h03, 32'h0000_00F0);
        accept_req("rst_wait");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_outs", {10'h0, typ, chan, value, ee}, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        read_chk("mid_rst_status", 5'h1E, 32'h0);
        read_chk("mid_rst_dac3", 5'h03, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_chk("no_replay", 10);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
